// File: rtl/imem_pkg.sv
// Shared constants and response type for the instruction-memory responder.
package imem_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } imem_resp_t;
endpackage

// File: rtl/imem_resp_fifo.sv
// Small in-order response queue; head entry is presented combinationally.
module imem_resp_fifo
  import imem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  input  logic       push,
  input  imem_resp_t push_data,
  input  logic       pop,
  output logic       valid,
  output imem_resp_t head
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  imem_resp_t        mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt;
  logic              do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid  = (cnt != '0);
  assign do_pop = pop && valid;
  // Idle output is zero so nothing stale is visible after reset or flush.
  assign head   = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction fetch responder: request pipeline feeding an
// in-order response queue, backed by a preloadable word array.
module imem_responder
  import imem_pkg::*;
#(
  parameter int LATENCY   = 1,
  parameter int DEPTH     = 2,
  parameter int ROM_WORDS = 256
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         imem_req_valid,
  input  logic [ADDR_W-1:0]            imem_req_addr,
  output logic                         imem_req_ready,
  output logic                         imem_resp_valid,
  output logic [DATA_W-1:0]            imem_resp_data,
  output logic                         imem_resp_err,
  input  logic                         imem_resp_ready,
  input  logic                         flush,
  input  logic                         load_en,
  input  logic [$clog2(ROM_WORDS)-1:0] load_addr,
  input  logic [DATA_W-1:0]            load_data
);
  localparam int AW = $clog2(ROM_WORDS);
  localparam int CW = $clog2(DEPTH + 1);

  // Contents survive reset; only the load port changes them.
  logic [DATA_W-1:0] rom [ROM_WORDS] = '{default: NOP};

  always_ff @(posedge clk) begin
    if (load_en) rom[load_addr] <= load_data;
  end

  logic [CW-1:0] count, count_nxt;
  logic          ready_q;
  logic          accept, resp_hs;
  logic [AW-1:0] req_idx;
  logic          req_err;

  assign imem_req_ready = ready_q;
  assign accept  = imem_req_valid && ready_q;
  assign resp_hs = imem_resp_valid && imem_resp_ready;
  assign req_idx = imem_req_addr[AW+1:2];
  assign req_err = (imem_req_addr[1:0] != 2'b00) ||
                   (imem_req_addr >= ADDR_W'(4 * ROM_WORDS));

  always_comb begin
    count_nxt = count;
    case ({accept, resp_hs})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Ready is registered from the next count so it never depends on this
  // cycle's handshakes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count   <= '0;
      ready_q <= 1'b0;
    end else if (flush) begin
      count   <= '0;
      ready_q <= 1'b1;
    end else begin
      count   <= count_nxt;
      ready_q <= (count_nxt < CW'(DEPTH));
    end
  end

  logic [LATENCY:1]         vld_pipe;
  logic [LATENCY:1][AW-1:0] idx_pipe;
  logic [LATENCY:1]         err_pipe;

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= accept;
      for (int i = 2; i <= LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    idx_pipe[1] <= req_idx;
    err_pipe[1] <= req_err;
    for (int i = 2; i <= LATENCY; i++) begin
      idx_pipe[i] <= idx_pipe[i-1];
      err_pipe[i] <= err_pipe[i-1];
    end
  end

  // Word is read as it enters the queue; a same-edge load is forwarded.
  imem_resp_t        push_data;
  logic [AW-1:0]     exit_idx;
  logic [DATA_W-1:0] rom_word;

  assign exit_idx = idx_pipe[LATENCY];

  always_comb begin
    rom_word = rom[exit_idx];
    if (load_en && (load_addr == exit_idx)) rom_word = load_data;
    push_data.err  = err_pipe[LATENCY];
    push_data.data = err_pipe[LATENCY] ? NOP : rom_word;
  end

  imem_resp_t head;

  imem_resp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .push      (vld_pipe[LATENCY]),
    .push_data (push_data),
    .pop       (imem_resp_ready),
    .valid     (imem_resp_valid),
    .head      (head)
  );

  assign imem_resp_data = head.data;
  assign imem_resp_err  = head.err;
endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter LATENCY, default 1, cycles from request accept to response visible; legal range 1..4.
REQ-002 Parameter DEPTH, default 2, maximum outstanding requests (in flight plus queued); legal range 1..4.
REQ-003 Parameter ROM_WORDS, default 256, number of 32-bit instruction words.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 imem_req_valid  input  1  CPU fetch request valid.
REQ-007 imem_req_addr  input  32  byte address of fetch.
REQ-008 imem_req_ready  output  1  responder can accept a request this cycle.
REQ-009 imem_resp_valid  output  1  response word available.
REQ-010 imem_resp_data  output  32  instruction word for oldest outstanding request.
REQ-011 imem_resp_err  output  1  response belongs to a misaligned or out-of-range address.
REQ-012 imem_resp_ready  input  1  CPU consumes response this cycle.
REQ-013 flush  input  1  discard all outstanding requests and responses.
REQ-014 load_en, load_addr, load_data  input  1/log2(ROM_WORDS)/32  preload write port into ROM array.

Function
REQ-015 Request accepted at a rising edge when imem_req_valid && imem_req_ready; response handshake when imem_resp_valid && imem_resp_ready.
REQ-016 imem_req_ready SHALL be a function of registered state only (outstanding count < DEPTH), with no combinational path from imem_resp_ready or imem_req_valid.
REQ-017 Outstanding count: +1 on accept, -1 on response handshake, unchanged on both in the same cycle; never exceeds DEPTH.
REQ-018 Accepted request enters a LATENCY-stage shift pipeline carrying address and err flag; on exiting it is pushed into a DEPTH-entry response FIFO.
REQ-019 Accept at edge N: imem_resp_valid high after edge N+LATENCY at earliest; back-to-back accepts give back-to-back responses when imem_resp_ready is held high.
REQ-020 imem_resp_valid = FIFO non-empty; imem_resp_data/imem_resp_err = FIFO head; held stable while valid && !ready.
REQ-021 Responses returned strictly in request order.
REQ-022 Word index = imem_req_addr[log2(ROM_WORDS)+1:2]; err when addr[1:0] != 0 or addr >= 4*ROM_WORDS.
REQ-023 On err the response SHALL carry data 32'h00000013 (NOP) and imem_resp_err=1; it consumes a slot like any response.
REQ-024 ROM read occurs at FIFO push time; a load_en write to the same word before push is visible in that response.
REQ-025 ROM array initialised to 32'h00000013 in every word at time zero; load_en writes load_data at load_addr on the edge.
REQ-026 flush at edge N: pipeline and FIFO emptied, count=0, a request accepted at edge N is dropped; imem_resp_valid low after edge N.
REQ-027 FIFO full with pipeline output pending is unreachable by REQ-017; no overflow or underflow is possible.

Reset
REQ-028 While reset_n=0 at an edge: count=0, pipeline valids=0, FIFO empty; imem_req_ready=0 during reset, 1 on the first cycle after release.
REQ-029 imem_resp_valid=0, imem_resp_data=0, imem_resp_err=0 after reset.
REQ-030 ROM contents are not affected by reset; load_en is honoured during reset.
REQ-031 Reset mid-operation discards all outstanding requests; no stale response appears after release.

Structure
REQ-032 Shared package imem_pkg holds the NOP constant 32'h00000013, the address/data widths, and the response struct {data, err}.
REQ-033 One sub-module, imem_resp_fifo (parameterised DEPTH, synchronous, first-word visible on output), holds queued responses.

Verification
REQ-034 Preload words 0..2 = 00500093, 00700113, 002081b3; requests to 0x0, 0x4, 0x8 back to back, resp_ready=1 -> responses in that order starting edge N+1, err=0.
REQ-035 DEPTH=2, resp_ready=0, requests every cycle -> exactly 2 accepted, req_ready low; raise resp_ready -> two responses, then req_ready high.
REQ-036 Requests to 0x2 and 0x400 (ROM_WORDS=256) -> data 00000013, err=1 for both.
REQ-037 LATENCY=3: accept at edge N -> resp_valid first high after edge N+3.
REQ-038 Two outstanding requests, flush pulsed with concurrent accept -> no response appears; next request to 0x4 returns 00700113.
REQ-039 Assert reset_n=0 with one queued response -> resp_valid=0 after reset; ROM word 0 still 00500093 on next fetch.
